// File: rtl/tick_timer_arbiter.sv
// Round-robin arbiter granting one shared prescaled tick timer to NREQ requesters.
// Optional abort input is compiled in when TIMER_ABORT_EN is defined.
module tick_timer_arbiter #(
    parameter int NREQ    = 4,
    parameter int CNT_W   = 16,
    parameter int DIV_EXP = 19
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
`ifdef TIMER_ABORT_EN
    input  logic                  abort_i,
`endif
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*CNT_W-1:0] len_i,
    output logic [NREQ-1:0]       grant_o,
    output logic [NREQ-1:0]       done_o,
    output logic                  busy_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_EXP-1:0] pre_q, pre_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   len_sel;
    logic               tick;

    // Highest-priority index is the one just after the last owner.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] w;
        int               idx;
        w = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (r[idx]) w = IDX_W'(idx);
        end
        return w;
    endfunction

    assign len_sel = len_i[int'(owner_q)*CNT_W +: CNT_W];
    assign tick    = &pre_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            cnt_q   <= '0;
            pre_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = LOAD;
                    owner_d = rr_pick(req_i, last_q);
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = (len_sel == '0) ? CNT_W'(1) : len_sel;
                pre_d   = '0;
            end
            RUN: begin
                pre_d = pre_q + DIV_EXP'(1);
                if (tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: state_d = IDLE;
        endcase
`ifdef TIMER_ABORT_EN
        if (abort_i && (state_q == LOAD || state_q == RUN)) begin
            state_d = IDLE;
            last_d  = owner_q;
        end
`endif
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        grant_d = '0;
        done_d  = '0;
        busy_d  = (state_d != IDLE);
        if (state_d != IDLE) grant_d[owner_d] = 1'b1;
        if (state_d == DONE) done_d[owner_d] = 1'b1;
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Scoreboard bench for tick_timer_arbiter with DIV_EXP=2, CNT_W=8, NREQ=4.
module tb_tick_timer_arbiter;

    localparam int NREQ    = 4;
    localparam int CNT_W   = 8;
    localparam int DIV_EXP = 2;

    typedef struct {
        int owner;
        int len;
        bit exp_done;
    } exp_t;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*CNT_W-1:0] len   = '0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
`ifdef TIMER_ABORT_EN
    logic                  abort = 1'b0;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   dones_seen = 0;
    exp_t gq[$];
    exp_t cur;
    bit   cur_active = 1'b0;
    int   grant_cyc  = 0;
    logic [NREQ-1:0] prev_grant = '0;
    logic [NREQ-1:0] prev_done  = '0;

    tick_timer_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .DIV_EXP(DIV_EXP)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
`ifdef TIMER_ABORT_EN
        .abort_i (abort),
`endif
        .req_i   (req),
        .len_i   (len),
        .grant_o (grant),
        .done_o  (done),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: grant order, done latency, done width.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_v;
        int eff, lat;
        if (prev_done !== '0) begin
            total++;
            if (done !== '0) begin
                bad++;
                $display("FAIL done_width: done=%b required=0000", done);
            end
        end
        if (grant !== '0 && prev_grant === '0) begin
            total++;
            if (gq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_grant: grant=%b required=0000", grant);
            end else begin
                cur = gq.pop_front();
                cur_active = 1'b1;
                grant_cyc = cyc;
                exp_v = '0;
                exp_v[cur.owner] = 1'b1;
                if (grant !== exp_v) begin
                    bad++;
                    $display("FAIL grant_order: grant=%b required=%b", grant, exp_v);
                end
            end
        end else if (grant === '0 && prev_grant !== '0 && cur_active) begin
            total++;
            cur_active = 1'b0;
            if (cur.exp_done) begin
                bad++;
                $display("FAIL grant_dropped: owner=%0d dropped without done, required done", cur.owner);
            end
        end
        if (done !== '0) begin
            total++;
            if (!cur_active || !cur.exp_done) begin
                bad++;
                $display("FAIL unexpected_done: done=%b required=0000", done);
            end else begin
                exp_v = '0;
                exp_v[cur.owner] = 1'b1;
                eff = (cur.len == 0) ? 1 : cur.len;
                lat = eff * (1 << DIV_EXP) + 1;
                if (done !== exp_v || (cyc - grant_cyc) != lat) begin
                    bad++;
                    $display("FAIL done_timing: done=%b at %0d cycles, required %b at %0d cycles",
                             done, cyc - grant_cyc, exp_v, lat);
                end
                cur_active = 1'b0;
                dones_seen++;
            end
        end
        prev_grant = grant;
        prev_done  = done;
    end

    task automatic set_len(input int i, input int v);
        len[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while (done[i] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL wait_done_%0d: no done after %0d cycles, required done", i, budget);
        end
    endtask

    task automatic wait_count(input int target, input int budget);
        int n = 0;
        while (dones_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL wait_count: dones=%0d required=%0d", dones_seen, target);
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((gq.size() != 0 || cur_active || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL wait_quiet: pending=%0d busy=%b required 0 pending idle", gq.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total += 3;
        if (grant !== '0) begin bad++; $display("FAIL rst_grant: grant=%b required=0000", grant); end
        if (done !== '0)  begin bad++; $display("FAIL rst_done: done=%b required=0000", done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: busy=%b required=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        set_len(1, 5);
        req[1] = 1'b1;
        gq.push_back('{owner: 1, len: 5, exp_done: 1'b0});
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 3;
        if (grant !== '0) begin bad++; $display("FAIL midrun_grant: grant=%b required=0000", grant); end
        if (done !== '0)  begin bad++; $display("FAIL midrun_done: done=%b required=0000", done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midrun_busy: busy=%b required=0", busy); end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: busy=%b required=0", busy); end
    endtask

    task automatic test_single();
        set_len(1, 3);
        req[1] = 1'b1;
        gq.push_back('{owner: 1, len: 3, exp_done: 1'b1});
        @(negedge clk);
        total += 2;
        if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant: grant=%b required=0010", grant); end
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: busy=%b required=1", busy); end
        wait_done(1, 40);
        req[1] = 1'b0;
        wait_quiet(20);
    endtask

    task automatic test_zero_len();
        set_len(2, 0);
        req[2] = 1'b1;
        gq.push_back('{owner: 2, len: 0, exp_done: 1'b1});
        wait_done(2, 40);
        req[2] = 1'b0;
        wait_quiet(20);
    endtask

    task automatic test_fairness();
        int start;
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        start = dones_seen;
        gq.push_back('{owner: 0, len: 1, exp_done: 1'b1});
        gq.push_back('{owner: 1, len: 1, exp_done: 1'b1});
        gq.push_back('{owner: 2, len: 1, exp_done: 1'b1});
        gq.push_back('{owner: 3, len: 1, exp_done: 1'b1});
        gq.push_back('{owner: 0, len: 1, exp_done: 1'b1});
        req = 4'b1111;
        wait_count(start + 5, 200);
        req = '0;
        wait_quiet(40);
    endtask

    task automatic test_back_to_back();
        int start;
        reset_dut();
        set_len(1, 2);
        set_len(3, 1);
        start = dones_seen;
        gq.push_back('{owner: 1, len: 2, exp_done: 1'b1});
        gq.push_back('{owner: 3, len: 1, exp_done: 1'b1});
        gq.push_back('{owner: 1, len: 2, exp_done: 1'b1});
        req = 4'b1010;
        wait_count(start + 3, 200);
        req = '0;
        wait_quiet(40);
    endtask

    task automatic test_drop_change();
        set_len(0, 4);
        req[0] = 1'b1;
        gq.push_back('{owner: 0, len: 4, exp_done: 1'b1});
        repeat (6) @(negedge clk);
        req[0] = 1'b0;
        set_len(0, 9);
        wait_quiet(100);
    endtask

`ifdef TIMER_ABORT_EN
    task automatic test_abort();
        reset_dut();
        set_len(3, 5);
        req = 4'b1000;
        gq.push_back('{owner: 3, len: 5, exp_done: 1'b0});
        repeat (4) @(negedge clk);
        set_len(0, 1);
        req = 4'b1001;
        gq.push_back('{owner: 0, len: 1, exp_done: 1'b1});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        req[3] = 1'b0;
        total++;
        if (grant !== '0) begin bad++; $display("FAIL abort_grant: grant=%b required=0000", grant); end
        wait_done(0, 40);
        req[0] = 1'b0;
        wait_quiet(40);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_fairness();
        test_back_to_back();
        test_drop_change();
`ifdef TIMER_ABORT_EN
        test_abort();
`endif
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
